// File: rtl/reg_bus_arb_pkg.sv
// Shared types and default widths for the register-bus arbiter.
package reg_bus_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } arb_state_t;

endpackage

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] request,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (request == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = request;
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates two register requesters onto one write/read register bus.
// Define REG_BUS_ARB_TIMEOUT_EN to abort stalled bus transfers after TIMEOUT_CYCLES.
module reg_bus_arbiter
  import reg_bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                bus_w_valid,
  output logic [ADDR_W-1:0]   bus_w_addr,
  output logic [DATA_W-1:0]   bus_w_data,
  input  logic                bus_w_ready,
  output logic                bus_r_valid,
  output logic [ADDR_W-1:0]   bus_r_addr,
  input  logic                bus_r_ready,
  input  logic [DATA_W-1:0]   bus_r_data
);

  arb_state_t        state;
  logic              last_grant;
  logic              id;
  logic [1:0]        grant;
  logic              accept;
  logic              sel_id;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .request    (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is gated by rstn so it reads 0 while reset is held.
  assign req_ready = (state == IDLE && rstn) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel_id    = grant[1];
  assign sel_write = sel_id ? req_write[1] : req_write[0];
  assign sel_addr  = sel_id ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
  assign sel_wdata = sel_id ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];

`ifdef REG_BUS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             rsp_err_q;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = rsp_err_q;

  // Counter is zero on every entry to WRITE/READ since it clears outside them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (state == WRITE || state == READ) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  localparam int unsigned tmo_unused = TIMEOUT_CYCLES;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      id          <= 1'b0;
      bus_w_valid <= 1'b0;
      bus_w_addr  <= '0;
      bus_w_data  <= '0;
      bus_r_valid <= 1'b0;
      bus_r_addr  <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
`ifdef REG_BUS_ARB_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            id <= sel_id;
            if (sel_write) begin
              state       <= WRITE;
              bus_w_valid <= 1'b1;
              bus_w_addr  <= sel_addr;
              bus_w_data  <= sel_wdata;
            end else begin
              state       <= READ;
              bus_r_valid <= 1'b1;
              bus_r_addr  <= sel_addr;
            end
          end
        end
        WRITE: begin
          if (bus_w_ready) begin
            state         <= RESP;
            bus_w_valid   <= 1'b0;
            rsp_rdata     <= '0;
            rsp_valid[id] <= 1'b1;
`ifdef REG_BUS_ARB_TIMEOUT_EN
            rsp_err_q     <= 1'b0;
          end else if (tmo_hit) begin
            state         <= RESP;
            bus_w_valid   <= 1'b0;
            rsp_rdata     <= '0;
            rsp_valid[id] <= 1'b1;
            rsp_err_q     <= 1'b1;
`endif
          end
        end
        READ: begin
          if (bus_r_ready) begin
            state         <= RESP;
            bus_r_valid   <= 1'b0;
            rsp_rdata     <= bus_r_data;
            rsp_valid[id] <= 1'b1;
`ifdef REG_BUS_ARB_TIMEOUT_EN
            rsp_err_q     <= 1'b0;
          end else if (tmo_hit) begin
            state         <= RESP;
            bus_r_valid   <= 1'b0;
            rsp_rdata     <= '0;
            rsp_valid[id] <= 1'b1;
            rsp_err_q     <= 1'b1;
`endif
          end
        end
        RESP: begin
          state      <= IDLE;
          last_grant <= id;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter; honours REG_BUS_ARB_TIMEOUT_EN when defined.
module tb_reg_bus_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          bus_w_valid;
  logic [AW-1:0] bus_w_addr;
  logic [DW-1:0] bus_w_data;
  logic          bus_w_ready;
  logic          bus_r_valid;
  logic [AW-1:0] bus_r_addr;
  logic          bus_r_ready;
  logic [DW-1:0] bus_r_data;

  typedef struct {
    logic          id;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  typedef struct {
    logic        id;
    int unsigned cyc;
  } acc_t;

  rsp_t        sb[$];
  acc_t        acc_log[$];
  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  int unsigned cyc      = 0;

  reg_bus_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .bus_w_valid (bus_w_valid),
    .bus_w_addr  (bus_w_addr),
    .bus_w_data  (bus_w_data),
    .bus_w_ready (bus_w_ready),
    .bus_r_valid (bus_r_valid),
    .bus_r_addr  (bus_r_addr),
    .bus_r_ready (bus_r_ready),
    .bus_r_data  (bus_r_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboard and accept logger, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    rsp_t e;
    chk("w_r_exclusive", 64'(bus_w_valid & bus_r_valid), 64'd0);
    if (rstn && rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_valid), e.id ? 64'd2 : 64'd1);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
    if (|(req_valid & req_ready)) acc_log.push_back('{req_ready[1], cyc});
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned n;
    rstn        = 1'b0;
    req_valid   = 2'b01;
    req_write   = 2'b00;
    req_addr    = '0;
    req_wdata   = '0;
    bus_w_ready = 1'b0;
    bus_r_ready = 1'b0;
    bus_r_data  = '0;

    // Reset state, with a pending request that must not see ready.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_bus_w_valid", 64'(bus_w_valid), 64'd0);
    chk("rst_bus_r_valid", 64'(bus_r_valid), 64'd0);
    chk("rst_bus_addr", 64'({bus_w_addr, bus_r_addr}), 64'd0);
    chk("rst_bus_w_data", 64'(bus_w_data), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    tick();
    req_valid = 2'b00;
    rstn      = 1'b1;

    // Read from requester 0: bus valid at T+1, response at T+2.
    tick();
    bus_r_ready       = 1'b1;
    bus_r_data        = 32'hDEADBEEF;
    req_valid         = 2'b01;
    req_write         = 2'b00;
    req_addr[AW-1:0]  = 8'h10;
    sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    @(negedge clk);
    chk("rd_req_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("rd_bus_r_valid", 64'(bus_r_valid), 64'd1);
    chk("rd_bus_r_addr", 64'(bus_r_addr), 64'h10);
    chk("rd_bus_w_valid", 64'(bus_w_valid), 64'd0);
    @(negedge clk);
    chk("rd_rsp_t2", 64'(rsp_valid), 64'd1);
    chk("rd_bus_r_drop", 64'(bus_r_valid), 64'd0);
    @(negedge clk);
    chk("rd_rsp_pulse", 64'(rsp_valid), 64'd0);

    // Write from requester 1 with bus_w_ready delayed 5 cycles.
    tick();
    bus_r_ready            = 1'b0;
    bus_w_ready            = 1'b0;
    req_valid              = 2'b10;
    req_write              = 2'b10;
    req_addr[2*AW-1:AW]    = 8'h05;
    req_wdata[2*DW-1:DW]   = 32'h12345678;
    sb.push_back('{1'b1, 32'h0, 1'b0});
    tick();
    req_valid = 2'b01;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("wr_hold_valid", 64'(bus_w_valid), 64'd1);
      chk("wr_hold_addr", 64'(bus_w_addr), 64'h05);
      chk("wr_hold_data", 64'(bus_w_data), 64'h12345678);
      chk("wr_busy_ready", 64'(req_ready), 64'd0);
      tick();
      if (k == 4) bus_w_ready = 1'b1;
      if (k == 5) begin
        bus_w_ready = 1'b0;
        req_valid   = 2'b00;
      end
    end
    @(negedge clk);
    chk("wr_valid_drop", 64'(bus_w_valid), 64'd0);
    chk("wr_rsp", 64'(rsp_valid), 64'd2);

    // Both requesters continuously valid after reset: grants alternate.
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    acc_log.delete();
    bus_w_ready          = 1'b1;
    bus_r_ready          = 1'b1;
    bus_r_data           = 32'hCAFEF00D;
    req_write            = 2'b10;
    req_addr[AW-1:0]     = 8'h20;
    req_addr[2*AW-1:AW]  = 8'h30;
    req_wdata[2*DW-1:DW] = 32'hA5A5A5A5;
    sb.push_back('{1'b0, 32'hCAFEF00D, 1'b0});
    sb.push_back('{1'b1, 32'h0, 1'b0});
    sb.push_back('{1'b0, 32'hCAFEF00D, 1'b0});
    sb.push_back('{1'b1, 32'h0, 1'b0});
    req_valid = 2'b11;
    for (int unsigned k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (acc_log.size() >= 4) break;
    end
    tick();
    req_valid = 2'b00;
    chk("rr_accepts", 64'(acc_log.size()), 64'd4);
    if (acc_log.size() >= 4) begin
      for (int unsigned k = 0; k < 4; k++) begin
        chk("rr_grant_order", 64'(acc_log[k].id), 64'(k % 2));
        if (k > 0) chk("rr_accept_spacing", 64'(acc_log[k].cyc - acc_log[k-1].cyc), 64'd3);
      end
    end
    repeat (4) @(negedge clk);

    // Reset while a read is stalled on the bus.
    tick();
    bus_r_ready      = 1'b0;
    bus_w_ready      = 1'b0;
    req_valid        = 2'b01;
    req_write        = 2'b00;
    req_addr[AW-1:0] = 8'h44;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("rst_mid_r_valid_pre", 64'(bus_r_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_r_valid_async", 64'(bus_r_valid), 64'd0);
    tick();
    bus_r_ready = 1'b1;
    rstn        = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
    end

    // Write with bus_w_ready held low.
    tick();
    bus_r_ready      = 1'b0;
    bus_w_ready      = 1'b0;
    req_valid        = 2'b01;
    req_write        = 2'b01;
    req_addr[AW-1:0] = 8'h33;
    req_wdata[DW-1:0] = 32'h55;
`ifdef REG_BUS_ARB_TIMEOUT_EN
    sb.push_back('{1'b0, 32'h0, 1'b1});
    tick();
    req_valid = 2'b00;
    n = 0;
    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_w_valid) n++;
      else break;
    end
    chk("tmo_valid_cycles", 64'(n), 64'd8);
    chk("tmo_rsp", 64'(rsp_valid), 64'd1);
`else
    tick();
    req_valid = 2'b00;
    n = 0;
    repeat (100) @(negedge clk);
    chk("stall_valid_held", 64'(bus_w_valid), 64'd1);
    sb.push_back('{1'b0, 32'h0, 1'b0});
    tick();
    bus_w_ready = 1'b1;
    tick();
    bus_w_ready = 1'b0;
`endif

    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
